shmem_arbiter: RTL and testbench
================================

# shmem_arbiter

Two-master Avalon-MM arbiter placed directly upstream of the on-chip shared memory (14-bit word address, 32-bit data, byte enables, 1-cycle registered read). It lets two Nios II data masters (m0, m1) share the memory's single port. It uses round-robin grant, waitrequest back-pressure and readdatavalid-tagged read returns, so each CPU sees a pipelined, variable-latency slave.

## Interface
- ADDR_W, 14, word address width (memory address bus)
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- clk  in  1  single clock for arbiter and memory
- reset_n  in  1  asynchronous, active-low reset
- m0_address / m1_address  in  ADDR_W  word address
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes (writes only)
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_lock / m1_lock  in  1  hold-grant request (used only with SHMEM_ARB_LOCK_EN)
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data, valid with readdatavalid
- m0_readdatavalid / m1_readdatavalid  out  1  read-return strobe
- mem_address  out  ADDR_W  to memory
- mem_byteenable  out  DATA_W/8  to memory
- mem_chipselect  out  1  to memory
- mem_write  out  1  to memory
- mem_writedata  out  DATA_W  to memory
- mem_clken  out  1  constant 1
- mem_readdata  in  DATA_W  from memory, 1 cycle after address

## Operation
- Request: mX_req = mX_read | mX_write. If both read and write are asserted, the transfer is a write.
- Grant is combinational, one master per cycle:
  - Only one request: that master is granted.
  - Both request: the master not in last_grant is granted.
  - last_grant register updates on every granted cycle.
- Granted master: memory signals are muxed from that port; mem_chipselect=1; mem_write = its write; its waitrequest=0.
- Losing or idle master: waitrequest = mX_req & ~grantX.
- No requests: mem_chipselect=0; other memory outputs hold master 0's values (don't-care).
- Read tracking: a granted read sets rd_pending=1 and rd_owner=granted index. Both registers update every cycle, so back-to-back reads pipeline at 1 per cycle.
- Read return, next cycle: mX_readdatavalid = rd_pending & (rd_owner==X).
- mX_readdata = mem_readdata when mX_readdatavalid is high, else 0.
- Writes produce no response.
- Reset state:
  - last_grant=1, so m0 wins the first tie.
  - rd_pending=0, rd_owner=0, lock_active=0.
  - All readdatavalid=0, all readdata=0.
- While reset_n=0: mem_chipselect=0 and waitrequest=1 on any requesting port.
- Reset asserted mid-read drops the pending return; no readdatavalid is issued after reset release.

## Timing
- Write: accepted in the grant cycle; memory write on that clk edge.
- Read latency: readdatavalid exactly 1 cycle after the accept cycle (the cycle with waitrequest=0).
- Throughput: 1 transfer/cycle total. Under continuous contention each master gets every other cycle.
- A master must hold address/data/command stable while waitrequest=1 (Avalon rule). The arbiter does not check this.

## Configuration
- SHMEM_ARB_LOCK_EN defined:
  - A granted transfer with mX_lock=1 sets lock_active=1 and lock_owner=X.
  - While lock_active, only lock_owner is granted; the other master stalls on waitrequest=1.
  - lock_active clears after lock_owner completes a granted transfer with mX_lock=0.
  - lock_active is cleared by reset.
- SHMEM_ARB_LOCK_EN undefined: lock inputs are ignored and there is no lock state; pure round-robin.

## Structure
- Package shmem_arb_pkg holds:
  - ADDR_W/DATA_W defaults
  - master index typedef (1 bit)
  - a transfer struct (address, byteenable, write, writedata)
- Sub-module shmem_rr_arbiter: 2-way round-robin grant, last_grant register and lock state. Inputs: req[1:0], lock[1:0]. Output: one-hot gnt[1:0].
- Top level: request muxing, read-return tracking, readdata steering.

## Test plan
- Reset: hold reset_n=0 with m0_read=1 → m0_waitrequest=1, mem_chipselect=0, readdatavalid=0. Release → m0 granted next cycle.
- Single write/read: m0 writes 0xDEADBEEF, BE=0xF to addr 0x0010, then reads 0x0010 → m0_readdatavalid 1 cycle after accept with readdata=0xDEADBEEF; m1_readdatavalid stays 0.
- Contention: m0 and m1 read addr 0x0001 / 0x0002 continuously for 8 cycles → grants alternate m0,m1,m0…, starting with m0; each gets 4 returns with correct data and owner.
- Byte enables: write 0x11223344 to 0x3FFB, then write 0xAABBCCDD with BE=0x5, then read → 0x11BB33DD.
- Lock (macro on): m1 issues locked write then unlocked read while m0 requests every cycle → m0_waitrequest=1 for both m1 cycles, then m0 granted.
- Reset mid-read: assert reset_n=0 on the accept edge of an m0 read → no readdatavalid on either port after release.

Source files
------------

// File: rtl/shmem_arb_pkg.sv
// shmem_arb_pkg: shared widths, master index and transfer record for the shared-memory arbiter
package shmem_arb_pkg;
  localparam int SHMEM_ADDR_W = 14;
  localparam int SHMEM_DATA_W = 32;
  typedef logic midx_t;
  typedef struct packed {
    logic [SHMEM_ADDR_W-1:0]   address;
    logic [SHMEM_DATA_W/8-1:0] byteenable;
    logic                      write;
    logic [SHMEM_DATA_W-1:0]   writedata;
  } xfer_t;
endpackage

// File: rtl/shmem_rr_arbiter.sv
// shmem_rr_arbiter: 2-way round-robin grant with last-grant memory; hold-lock state when SHMEM_ARB_LOCK_EN is defined
module shmem_rr_arbiter
  import shmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);
  midx_t      last_grant;
  logic [1:0] rr_gnt;
  assign rr_gnt = {req[1] & (~req[0] | ~last_grant), req[0] & (~req[1] | last_grant)};
`ifdef SHMEM_ARB_LOCK_EN
  logic  lock_active;
  midx_t lock_owner;
  assign gnt = lock_active ? req & (lock_owner ? 2'b10 : 2'b01) : rr_gnt;
  // Each granted transfer's lock bit decides whether its master keeps exclusive ownership
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      lock_active <= 1'b0;
      lock_owner  <= 1'b0;
    end else if (|gnt) begin
      lock_active <= lock[gnt[1]];
      lock_owner  <= gnt[1];
    end
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign gnt = rr_gnt;
`endif
  // Remember the latest winner so the other master wins the next tie
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last_grant <= 1'b1;
    else if (|gnt) last_grant <= gnt[1];
endmodule

// File: rtl/shmem_arbiter.sv
// shmem_arbiter: two-master Avalon-MM arbiter in front of a 1-cycle-read shared memory (lock option: SHMEM_ARB_LOCK_EN)
module shmem_arbiter
  import shmem_arb_pkg::*;
#(
  parameter int ADDR_W = SHMEM_ADDR_W,
  parameter int DATA_W = SHMEM_DATA_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic                m0_lock,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic                m1_lock,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);
  logic [1:0] req, gnt;
  midx_t      sel, rd_owner;
  logic       rd_pending, rd_accept;
  assign req = {m1_read | m1_write, m0_read | m0_write};
  shmem_rr_arbiter u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req & {2{reset_n}}),
    .lock    ({m1_lock, m0_lock}),
    .gnt     (gnt)
  );
  assign sel            = gnt[1];
  assign mem_chipselect = |gnt;
  assign mem_address    = sel ? m1_address : m0_address;
  assign mem_byteenable = sel ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = sel ? m1_writedata : m0_writedata;
  assign mem_write      = sel ? m1_write : gnt[0] & m0_write;
  assign mem_clken      = 1'b1;
  assign m0_waitrequest = req[0] & ~gnt[0];
  assign m1_waitrequest = req[1] & ~gnt[1];
  assign rd_accept      = sel ? m1_read & ~m1_write : gnt[0] & m0_read & ~m0_write;
  // Tag each accepted read so its data returns to the right port on the next cycle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      rd_pending <= rd_accept;
      rd_owner   <= sel;
    end
  assign m0_readdatavalid = rd_pending & ~rd_owner;
  assign m1_readdatavalid = rd_pending & rd_owner;
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;
endmodule

// File: tb/tb_shmem_arbiter.sv
// tb_shmem_arbiter: vector table plus read-return scoreboard for shmem_arbiter (lock checks follow SHMEM_ARB_LOCK_EN)
module tb_shmem_arbiter;
  import shmem_arb_pkg::*;
  logic clk = 1'b0, reset_n;
  logic [13:0] m0_address, m1_address, mem_address;
  logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
  logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [31:0] m0_writedata, m1_writedata, mem_writedata, mem_readdata;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic        mem_chipselect, mem_write, mem_clken;

  shmem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_lock(m0_lock), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_lock(m1_lock), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic owner; logic [31:0] data; } exp_t;
  typedef struct { logic [1:0] rd, wr, acc; logic mw; } vec_t;
  exp_t sb[$];
  logic [31:0] mem  [0:16383];
  logic [31:0] refm [0:16383];
  int n_cmp = 0, n_bad = 0;
  bit hold_sb = 0;

  initial for (int i = 0; i < 16384; i++) begin mem[i] = 32'h0; refm[i] = 32'h0; end

  // Behavioural on-chip memory: byte-lane writes, registered read
  always @(posedge clk) begin
    mem_readdata <= mem[mem_address];
    if (mem_chipselect && mem_write)
      for (int b = 0; b < 4; b++)
        if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic record(input logic p, input xfer_t t);
    if (t.write) begin
      for (int b = 0; b < 4; b++)
        if (t.byteenable[b]) refm[t.address][8*b +: 8] = t.writedata[8*b +: 8];
    end else sb.push_back(exp_t'{owner: p, data: refm[t.address]});
  endtask

  task automatic drive(input logic [1:0] rd, input logic [1:0] wr, input logic [1:0] lk,
                       input logic [13:0] a0, input logic [13:0] a1, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [3:0] be0, input logic [3:0] be1,
                       output logic [1:0] acc);
    @(negedge clk);
    m0_read = rd[0]; m0_write = wr[0]; m0_lock = lk[0]; m0_address = a0; m0_writedata = d0; m0_byteenable = be0;
    m1_read = rd[1]; m1_write = wr[1]; m1_lock = lk[1]; m1_address = a1; m1_writedata = d1; m1_byteenable = be1;
    #1;
    acc = {(rd[1] | wr[1]) & ~m1_waitrequest, (rd[0] | wr[0]) & ~m0_waitrequest} & {2{reset_n}};
    if (!hold_sb) begin
      if (acc[0]) record(1'b0, xfer_t'{address: a0, byteenable: be0, write: wr[0], writedata: d0});
      if (acc[1]) record(1'b1, xfer_t'{address: a1, byteenable: be1, write: wr[1], writedata: d1});
    end
  endtask

  task automatic idle();
    logic [1:0] acc;
    drive(2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 32'h0, 4'h0, 4'h0, acc);
  endtask

  task automatic single(input logic p, input logic wr, input logic [13:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [1:0] m, acc;
    m = p ? 2'b10 : 2'b01;
    acc = 2'b00;
    for (int i = 0; i < 8 && !acc[p]; i++) drive(wr ? 2'b00 : m, wr ? m : 2'b00, 2'b00, a, a, d, d, be, be, acc);
    chk("single_accept", acc[p], 1'b1);
  endtask

  // Every read return is matched against the oldest accepted read
  always @(negedge clk) begin
    exp_t e;
    if (m0_readdatavalid || m1_readdatavalid) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_return: valid m0=%0b m1=%0b with nothing outstanding", m0_readdatavalid, m1_readdatavalid);
      end else begin
        e = sb.pop_front();
        chk("ret_owner", m1_readdatavalid, e.owner);
        chk("ret_data", m1_readdatavalid ? m1_readdata : m0_readdata, e.data);
        chk("ret_other_zero", m1_readdatavalid ? m0_readdata : m1_readdata, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [15];
    logic [1:0] acc;
    tbl[0]  = '{rd: 2'b01, wr: 2'b00, acc: 2'b01, mw: 1'b0};
    tbl[1]  = '{rd: 2'b10, wr: 2'b00, acc: 2'b10, mw: 1'b0};
    for (int i = 2; i < 10; i++) tbl[i] = '{rd: 2'b11, wr: 2'b00, acc: (i % 2 == 0) ? 2'b01 : 2'b10, mw: 1'b0};
    tbl[10] = '{rd: 2'b00, wr: 2'b01, acc: 2'b01, mw: 1'b1};
    tbl[11] = '{rd: 2'b00, wr: 2'b00, acc: 2'b00, mw: 1'b0};
    tbl[12] = '{rd: 2'b11, wr: 2'b11, acc: 2'b10, mw: 1'b1};
    tbl[13] = '{rd: 2'b11, wr: 2'b00, acc: 2'b01, mw: 1'b0};
    tbl[14] = '{rd: 2'b11, wr: 2'b00, acc: 2'b10, mw: 1'b0};

    reset_n = 1'b0;
    m0_read = 1'b1; m0_write = 1'b0; m0_lock = 1'b0; m0_address = 14'h0; m0_writedata = 32'h0; m0_byteenable = 4'h0;
    m1_read = 1'b0; m1_write = 1'b0; m1_lock = 1'b0; m1_address = 14'h0; m1_writedata = 32'h0; m1_byteenable = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_wait", m0_waitrequest, 1'b1);
    chk("rst_cs", mem_chipselect, 1'b0);
    chk("rst_valid", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
    chk("rst_rdata", m0_readdata, 32'h0);
    reset_n = 1'b1;
    #1;
    chk("rel_wait", m0_waitrequest, 1'b0);
    chk("rel_cs", mem_chipselect, 1'b1);
    sb.push_back(exp_t'{owner: 1'b0, data: refm[0]});

    idle();
    single(1'b0, 1'b1, 14'h0010, 32'hDEADBEEF, 4'hF);
    single(1'b0, 1'b0, 14'h0010, 32'h0, 4'hF);
    idle();
    chk("rd_latency_valid", m0_readdatavalid, 1'b1);
    chk("rd_data", m0_readdata, 32'hDEADBEEF);
    chk("rd_m1_quiet", m1_readdatavalid, 1'b0);

    single(1'b0, 1'b1, 14'h0001, 32'h01010101, 4'hF);
    single(1'b1, 1'b1, 14'h0002, 32'h02020202, 4'hF);
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rd, tbl[i].wr, 2'b00, 14'h0001, 14'h0002, 32'hA0000000 + i, 32'hB0000000 + i, 4'hF, 4'hF, acc);
      chk($sformatf("vec%0d_grant", i), acc, tbl[i].acc);
      chk($sformatf("vec%0d_cs", i), mem_chipselect, |tbl[i].acc);
      chk($sformatf("vec%0d_mwrite", i), mem_write, tbl[i].mw);
      chk($sformatf("vec%0d_addr", i), mem_address, tbl[i].acc[1] ? 14'h0002 : 14'h0001);
    end
    idle();

    single(1'b0, 1'b1, 14'h3FFB, 32'h11223344, 4'hF);
    single(1'b0, 1'b1, 14'h3FFB, 32'hAABBCCDD, 4'h5);
    single(1'b0, 1'b0, 14'h3FFB, 32'h0, 4'hF);
    idle();
    chk("be_valid", m0_readdatavalid, 1'b1);
    chk("be_data", m0_readdata, 32'h11BB33DD);

    single(1'b0, 1'b0, 14'h0001, 32'h0, 4'hF);
    drive(2'b01, 2'b10, 2'b10, 14'h0001, 14'h0005, 32'h0, 32'h55AA0001, 4'hF, 4'hF, acc);
    chk("lock_c1", acc, 2'b10);
    drive(2'b11, 2'b00, 2'b00, 14'h0001, 14'h0005, 32'h0, 32'h0, 4'hF, 4'hF, acc);
`ifdef SHMEM_ARB_LOCK_EN
    chk("lock_c2", acc, 2'b10);
`else
    chk("lock_c2", acc, 2'b01);
`endif
    drive(2'b01, 2'b00, 2'b00, 14'h0001, 14'h0005, 32'h0, 32'h0, 4'hF, 4'hF, acc);
    chk("lock_c3", acc, 2'b01);
    idle();
    idle();

    hold_sb = 1;
    drive(2'b01, 2'b00, 2'b00, 14'h0010, 14'h0, 32'h0, 32'h0, 4'hF, 4'h0, acc);
    chk("rst_mid_accept", acc, 2'b01);
    hold_sb = 0;
    @(posedge clk);
    #1 reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      idle();
      chk("rst_mid_valid", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
      chk("rst_mid_cs", mem_chipselect, 1'b0);
    end
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("post_rst_valid", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
    end
    idle();
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
